serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
- Bit-serial ALU sequencer that drives one full-adder bit cell with one bit per cycle, LSB first.
- Captures two WIDTH-bit operands and an opsel, shifts operand bits into the bit cell, and holds the carry between bits in a flop.
- Assembles the result plus C/V/Z flags.
- Sits directly upstream of the fa bit cell: it feeds a, b, cin and opsel, and consumes s and cout.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk      in   1      rising-edge clock
- rst_n    in   1      asynchronous active-low reset
- start    in   1      request; accepted only when busy=0
- opsel    in   3      operation code, sampled with start
- a_in     in   WIDTH  operand A, sampled with start
- b_in     in   WIDTH  operand B, sampled with start
- busy     out  1      high from the accept edge until done deasserts
- done     out  1      one-cycle completion pulse
- err      out  1      high with done when opsel=3'b111
- result   out  WIDTH  last completed result
- c_flag   out  1      carry-out of the last completed op
- v_flag   out  1      signed overflow of the last completed op
- z_flag   out  1      result==0 for the last completed op

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, FSM goes to IDLE, internal shift registers and carry flop are cleared. Reset mid-operation aborts the op with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: latch opsel, A, B; load carry flop with the initial cin. Illegal opsel goes to DONE with err; otherwise go to RUN with bit counter=0.
  - RUN: each cycle presents A[0], B[0], carry to the bit cell. At the clock edge: shift s into the result shift register MSB side, shift A and B right by 1, carry <= cout, counter++. After WIDTH RUN cycles go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Initial cin and meaning per opsel (bit cell b-operand selection noted):
  - 000 ADD: b=B, cin=0.
  - 001 SUB: b=~B, cin=1; computes A-B, c_flag=1 means no borrow.
  - 010 PASS: b=0, cin=0; result=A.
  - 011 SUBM1: b=~B, cin=0; computes A-B-1.
  - 100 INC: b=0, cin=1.
  - 101 DEC: b=all ones, cin=0.
  - 110 ADC: b=B, cin=c_flag from the previous completed op.
  - 111 illegal: the bit cell is never clocked with this code.
- Latency: accept edge to done high = WIDTH+1 cycles. busy goes high the cycle after accept and falls when done falls.
- Output update: result, c_flag, v_flag, z_flag load at the edge entering DONE. They hold until the next successful completion.
  - v_flag = carry into MSB XOR carry out of MSB.
  - Illegal op: err=1 and done=1 together for one cycle; result and flags are unchanged, including c_flag for a subsequent ADC.
- err is 0 whenever done is 0.
- start while busy: ignored, with no queuing. start in the DONE cycle is also ignored. Back-to-back issue is possible from the IDLE cycle that follows DONE.
- Operand and opsel inputs are only sampled on the accept edge. Changes during busy have no effect.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [2:0] opsel_t with the eight codes above (OP_ADD ... OP_ILLEGAL).
  - typedef enum state_t {IDLE, RUN, DONE}.
  - Function init_cin(opsel_t, logic cflag).
- One sub-module: the existing fa bit cell, instantiated once, fed by the shift-register LSBs and the carry flop.
- Counter width: $clog2(WIDTH+1).

Test Plan:
- ADD A=8'h5A B=8'h3C -> done exactly 9 cycles after accept; result=8'h96, c=0, v=1, z=0, err=0.
- SUB A=8'h10 B=8'h20 -> result=8'hF0, c=0, v=0. Then INC A=8'hFF -> result=8'h00, c=1, z=1.
- ADC chaining:
  - INC 8'hFF (c=1), then ADC A=8'h01 B=8'h01 -> result=8'h03, c=0.
  - Then DEC A=8'h00 -> result=8'hFF, c=0.
- Illegal: after ADD result 8'h96, issue opsel=3'b111 -> done and err high the cycle after accept, result stays 8'h96, flags unchanged, busy=1 for exactly 1 cycle.
- start pulsed with different operands at cycle 3 of a busy ADD -> ignored; only one done pulse, first op's result.
- rst_n low for 1 cycle mid-RUN:
  - Outputs are 0 immediately (asynchronous) and no done pulse occurs.
  - Then ADC 8'h01+8'h01 -> 8'h02, because the carry was cleared by reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its full-adder bit cell.
// Contents:
//   opsel_t  - operation codes accepted by the sequencer
//   state_t  - sequencer FSM states
//   init_cin - carry value loaded into the carry flop when an operation starts
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_PASS    = 3'b010,
    OP_SUBM1   = 3'b011,
    OP_INC     = 3'b100,
    OP_DEC     = 3'b101,
    OP_ADC     = 3'b110,
    OP_ILLEGAL = 3'b111
  } opsel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // SUB and INC start with a forced carry (two's complement / +1); ADC chains
  // the carry-out of the previous completed operation.
  function automatic logic init_cin(opsel_t op, logic cflag);
    logic cin;
    case (op)
      OP_SUB,
      OP_INC:  cin = 1'b1;
      OP_ADC:  cin = cflag;
      default: cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/fa.sv
// Single full-adder bit cell with per-operation selection of the b operand.
// Ports:
//   a     - operand A bit
//   b     - raw operand B bit
//   cin   - carry in
//   opsel - current operation; picks b, ~b, 0 or 1 as the effective b bit
//   s     - sum bit
//   cout  - carry out
module fa
  import alu_pkg::*;
(
  input  logic   a,
  input  logic   b,
  input  logic   cin,
  input  opsel_t opsel,
  output logic   s,
  output logic   cout
);

  logic bEff;

  // Effective b bit: subtraction uses the inverted operand, PASS/INC add
  // nothing, DEC adds all ones (i.e. -1).
  always_comb begin
    bEff = b;
    case (opsel)
      OP_ADD,
      OP_ADC:   bEff = b;
      OP_SUB,
      OP_SUBM1: bEff = ~b;
      OP_PASS,
      OP_INC:   bEff = 1'b0;
      OP_DEC:   bEff = 1'b1;
      default:  bEff = b;
    endcase
  end

  assign s    = a ^ bEff ^ cin;
  assign cout = (a & bEff) | (cin & (a ^ bEff));

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer. Captures two WIDTH-bit operands and an opsel,
// then feeds one full-adder bit cell LSB first, one bit per clock, keeping
// the inter-bit carry in a flop. Result and C/V/Z flags update on completion.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start, opsel        - request and operation code (sampled on accept)
//   a_in, b_in          - operands (sampled on accept)
//   busy                - high from the cycle after accept until done falls
//   done, err           - one-cycle completion pulse; err marks illegal opsel
//   result              - last completed result
//   c_flag/v_flag/z_flag- carry, signed overflow, zero of last completed op
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opsel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  opsel_t           opsel_q, opsel_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] resSh_q, resSh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             errFlag_q, errFlag_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic             faS;
  logic             faCout;
  logic [WIDTH-1:0] resNext;
  opsel_t           opselIn;

  fa uFa (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .cin  (carry_q),
    .opsel(opsel_q),
    .s    (faS),
    .cout (faCout)
  );

  assign opselIn = opsel_t'(opsel);
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  assign resNext = {faS, resSh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opsel_q   <= OP_ADD;
      aSh_q     <= '0;
      bSh_q     <= '0;
      resSh_q   <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      errFlag_q <= 1'b0;
      result_q  <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      opsel_q   <= opsel_d;
      aSh_q     <= aSh_d;
      bSh_q     <= bSh_d;
      resSh_q   <= resSh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      errFlag_q <= errFlag_d;
      result_q  <= result_d;
      c_q       <= c_d;
      v_q       <= v_d;
      z_q       <= z_d;
    end
  end

  // An illegal opsel skips RUN entirely, so the bit cell never computes with
  // it and the visible result/flags (including the ADC carry) stay intact.
  always_comb begin
    state_d   = state_q;
    opsel_d   = opsel_q;
    aSh_d     = aSh_q;
    bSh_d     = bSh_q;
    resSh_d   = resSh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    errFlag_d = errFlag_q;
    result_d  = result_q;
    c_d       = c_q;
    v_d       = v_q;
    z_d       = z_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opsel_d = opselIn;
          aSh_d   = a_in;
          bSh_d   = b_in;
          resSh_d = '0;
          carry_d = init_cin(opselIn, c_q);
          cnt_d   = '0;
          if (opselIn == OP_ILLEGAL) begin
            errFlag_d = 1'b1;
            state_d   = DONE;
          end else begin
            errFlag_d = 1'b0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        resSh_d = resNext;
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        carry_d = faCout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = DONE;
          result_d = resNext;
          c_d      = faCout;
          // carry_q is the carry into the MSB on the final bit
          v_d      = carry_q ^ faCout;
          z_d      = ~|resNext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = (state_q == DONE) && errFlag_q;
  assign result = result_q;
  assign c_flag = c_q;
  assign v_flag = v_q;
  assign z_flag = z_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: table of directed vectors,
// hand-written multi-cycle corner cases, and randomized ops checked against
// a word-level arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opsel = 3'b000;
  logic [W-1:0] aIn = '0;
  logic [W-1:0] bIn = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         cFlag;
  logic         vFlag;
  logic         zFlag;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] modelResult = '0;
  logic         modelC = 1'b0;
  logic         modelV = 1'b0;
  logic         modelZ = 1'b0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         e;
  } vec_t;

  vec_t tbl[19];

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .opsel (opsel),
    .a_in  (aIn),
    .b_in  (bIn),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .result(result),
    .c_flag(cFlag),
    .v_flag(vFlag),
    .z_flag(zFlag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Word-level reference: the whole operation is one addition a + b' + cin.
  task automatic refOp(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] bv;
    logic         cin;
    logic [W:0]   sum;
    if (op == 3'b111) return;
    case (op)
      3'd0, 3'd6: bv = b;
      3'd1, 3'd3: bv = ~b;
      3'd2, 3'd4: bv = '0;
      default:    bv = '1;
    endcase
    if (op == 3'd1 || op == 3'd4) cin = 1'b1;
    else if (op == 3'd6)          cin = modelC;
    else                          cin = 1'b0;
    sum = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, cin};
    modelResult = sum[W-1:0];
    modelC      = sum[W];
    modelV      = (a[W-1] == bv[W-1]) && (sum[W-1] != a[W-1]);
    modelZ      = (sum[W-1:0] == '0);
  endtask

  // Issues one op and waits (bounded) for done. Returns cycles from the
  // accept edge to done, busy cycles seen, err at done and err leaks before.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, output int lat,
                               output int busyCnt, output logic errAtDone,
                               output int errLeak);
    @(negedge clk);
    start = 1'b1;
    opsel = op;
    aIn   = a;
    bIn   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    opsel = 3'($urandom);
    aIn   = W'($urandom);
    bIn   = W'($urandom);
    lat = 0;
    busyCnt = 0;
    errLeak = 0;
    errAtDone = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
      if (done) begin
        errAtDone = err;
        break;
      end
      if (err) errLeak++;
    end
    @(negedge clk);
    checkOutput("done_falls", {31'b0, done}, 32'd0);
    checkOutput("busy_falls", {31'b0, busy}, 32'd0);
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    int   lat, busyCnt, errLeak;
    logic errAtDone;
    int   expLat;
    refOp(op, a, b);
    expLat = (op == 3'b111) ? 1 : W + 1;
    applyStimulus(op, a, b, lat, busyCnt, errAtDone, errLeak);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busy"}, busyCnt, expLat);
    checkOutput({tag, "_errleak"}, errLeak, 0);
    checkOutput({tag, "_err"}, {31'b0, errAtDone}, {31'b0, op == 3'b111});
    checkOutput({tag, "_result"}, {24'b0, result}, {24'b0, modelResult});
    checkOutput({tag, "_c"}, {31'b0, cFlag}, {31'b0, modelC});
    checkOutput({tag, "_v"}, {31'b0, vFlag}, {31'b0, modelV});
    checkOutput({tag, "_z"}, {31'b0, zFlag}, {31'b0, modelZ});
  endtask

  initial begin
    int   lat, busyCnt, errLeak, pulses, doneCyc;
    logic errAtDone;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{3'd0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'd4, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3'd6, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd5, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'd7, 8'h12, 8'h34, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{3'd2, 8'hA5, 8'h77, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'd3, 8'h05, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd4, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'd7, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{3'd6, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3'd1, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{3'd6, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{3'd5, 8'h80, 8'h00, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{3'd3, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{3'd7, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_result", {24'b0, result}, 32'd0);
    checkOutput("rst_flags", {29'b0, cFlag, vFlag, zFlag}, 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      refOp(tbl[i].op, tbl[i].a, tbl[i].b);
      applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, lat, busyCnt, errAtDone, errLeak);
      checkOutput($sformatf("tbl%0d_latency", i), lat, tbl[i].e ? 1 : W + 1);
      checkOutput($sformatf("tbl%0d_busy", i), busyCnt, tbl[i].e ? 1 : W + 1);
      checkOutput($sformatf("tbl%0d_err", i), {31'b0, errAtDone}, {31'b0, tbl[i].e});
      checkOutput($sformatf("tbl%0d_errleak", i), errLeak, 0);
      checkOutput($sformatf("tbl%0d_result", i), {24'b0, result}, {24'b0, tbl[i].res});
      checkOutput($sformatf("tbl%0d_c", i), {31'b0, cFlag}, {31'b0, tbl[i].c});
      checkOutput($sformatf("tbl%0d_v", i), {31'b0, vFlag}, {31'b0, tbl[i].v});
      checkOutput($sformatf("tbl%0d_z", i), {31'b0, zFlag}, {31'b0, tbl[i].z});
    end

    // start while busy (cycle 3) and during the DONE cycle is ignored
    refOp(3'd0, 8'h5A, 8'h3C);
    @(negedge clk);
    start = 1'b1; opsel = 3'd0; aIn = 8'h5A; bIn = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    doneCyc = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin
        pulses++;
        if (doneCyc == 0) doneCyc = cyc;
      end
      if (cyc == 3 || (done && pulses == 1)) begin
        start = 1'b1; opsel = 3'd1; aIn = 8'hFF; bIn = 8'h01;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("ignore_pulses", pulses, 1);
    checkOutput("ignore_latency", doneCyc, W + 1);
    checkOutput("ignore_result", {24'b0, result}, {24'b0, modelResult});
    checkOutput("ignore_v", {31'b0, vFlag}, {31'b0, modelV});

    // Reset mid-RUN aborts, clears outputs and the ADC carry
    runAndCheck("pre_rst_inc", 3'd4, 8'hFF, 8'h00);
    @(negedge clk);
    start = 1'b1; opsel = 3'd0; aIn = 8'h12; bIn = 8'h34;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_result", {24'b0, result}, 32'd0);
    checkOutput("async_c", {31'b0, cFlag}, 32'd0);
    checkOutput("async_z", {31'b0, zFlag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelResult = '0; modelC = 1'b0; modelV = 1'b0; modelZ = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("rst_no_done", pulses, 0);
    runAndCheck("post_rst_adc", 3'd6, 8'h01, 8'h01);
    checkOutput("post_rst_adc_value", {24'b0, result}, 32'h02);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      runAndCheck($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
